// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the UART bus loader.
// Opcodes, reply bytes and the command/bus-port FSM state sets.
package loader_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_PING  = 8'h50;
  localparam logic [7:0] BYTE_ACK = 8'h2E;
  localparam logic [7:0] BYTE_ERR = 8'h3F;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_LO,
    ADDR_HI,
    LEN,
    WDATA,
    WRITE,
    RREQ,
    RWAIT,
    RSEND,
    ACK
  } state_e;

  typedef enum logic [1:0] {
    BP_IDLE,
    BP_WRITE,
    BP_SETTLE,
    BP_WAIT
  } bp_state_e;

endpackage

// File: rtl/uart_bus_loader_if.sv
// Bus-side signal bundle between the loader (master) and the memory responder.
interface uart_bus_loader_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic        bus_wr_en;
  logic        bus_rd_req;
  logic [7:0]  bus_rd_data;
  logic        bus_ready;

  modport master (
    output bus_addr, bus_wr_data, bus_wr_en, bus_rd_req,
    input  bus_rd_data, bus_ready
  );

  modport slave (
    input  bus_addr, bus_wr_data, bus_wr_en, bus_rd_req,
    output bus_rd_data, bus_ready
  );
endinterface

// File: rtl/bus_port.sv
// Single-transfer bus handshake: one-cycle write strobe, or a read with
// settle window and bounded wait for bus_ready. Reports done/timeout.
module bus_port
  import loader_pkg::*;
#(
  parameter int unsigned BUS_WAIT_MAX = 255,
  parameter int unsigned READ_SETTLE  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_wr_i,
  input  logic              start_rd_i,
  input  logic [15:0]       addr_i,
  input  logic [7:0]        wdata_i,
  output logic              done_o,
  output logic              timeout_o,
  output logic [7:0]        rdata_o,
  uart_bus_loader_if.master bus
);

  localparam int unsigned CNT_W = 16;

  bp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= BP_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    rdata_o   = '1;
    unique case (state_q)
      BP_IDLE: begin
        if (start_wr_i) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          state_d = BP_WRITE;
        end else if (start_rd_i) begin
          addr_d  = addr_i;
          cnt_d   = '0;
          state_d = (READ_SETTLE == 0) ? BP_WAIT : BP_SETTLE;
        end
      end
      BP_WRITE: begin
        // Strobe cycle completes the write; returning to idle guarantees a gap.
        done_o  = 1'b1;
        state_d = BP_IDLE;
      end
      BP_SETTLE: begin
        if (cnt_q == CNT_W'(READ_SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = BP_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BP_WAIT: begin
        if (bus.bus_ready) begin
          done_o  = 1'b1;
          rdata_o = bus.bus_rd_data;
          state_d = BP_IDLE;
        end else if (cnt_q == CNT_W'(BUS_WAIT_MAX - 1)) begin
          done_o    = 1'b1;
          timeout_o = 1'b1;
          state_d   = BP_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = BP_IDLE;
    endcase
  end

  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wdata_q;
  assign bus.bus_wr_en   = (state_q == BP_WRITE);
  assign bus.bus_rd_req  = (state_q == BP_SETTLE) || (state_q == BP_WAIT);

endmodule

// File: rtl/uart_bus_loader.sv
// UART command loader: decodes W/R/P commands from received bytes, drives
// the bus through bus_port and paces replies into the UART transmitter.
module uart_bus_loader
  import loader_pkg::*;
#(
  parameter int unsigned BUS_WAIT_MAX = 255,
  parameter int unsigned READ_SETTLE  = 2
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  input  logic              tx_busy,
  output logic              cpu_halt,
  output logic              cmd_error,
  uart_bus_loader_if.master bus
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [8:0]  len_q, len_d;
  logic        is_rd_q, is_rd_d;
  logic [7:0]  ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  tx_data_q;
  logic        tx_wr_en_q, cmd_error_q, cpu_halt_q;
  logic [1:0]  gap_q;

  logic        start_wr, start_rd, tx_fire, err, tx_ok;
  logic [7:0]  tx_byte;
  logic        bp_done, bp_timeout;
  logic [7:0]  bp_rdata;

  bus_port #(
    .BUS_WAIT_MAX(BUS_WAIT_MAX),
    .READ_SETTLE (READ_SETTLE)
  ) u_bus_port (
    .clk_i     (sys_clk),
    .rst_i     (reset),
    .start_wr_i(start_wr),
    .start_rd_i(start_rd),
    .addr_i    (addr_q),
    .wdata_i   (rx_data),
    .done_o    (bp_done),
    .timeout_o (bp_timeout),
    .rdata_o   (bp_rdata),
    .bus       (bus)
  );

  // gap_q holds off the next pulse for two cycles while tx_busy catches up.
  assign tx_ok = !tx_busy && (gap_q == '0);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    is_rd_d  = is_rd_q;
    ack_d    = ack_q;
    rdata_d  = rdata_q;
    start_wr = 1'b0;
    start_rd = 1'b0;
    tx_fire  = 1'b0;
    tx_byte  = tx_data_q;
    err      = 1'b0;
    if (rx_valid && (state_q inside {RREQ, RWAIT, RSEND, WRITE, ACK})) err = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_WRITE: begin is_rd_d = 1'b0; state_d = ADDR_LO; end
            OP_READ:  begin is_rd_d = 1'b1; state_d = ADDR_LO; end
            OP_PING:  begin ack_d = OP_PING; state_d = ACK; end
            default:  begin ack_d = BYTE_ERR; err = 1'b1; state_d = ACK; end
          endcase
        end
      end
      ADDR_LO: if (rx_valid) begin addr_d[7:0] = rx_data; state_d = ADDR_HI; end
      ADDR_HI: if (rx_valid) begin addr_d[15:8] = rx_data; state_d = LEN; end
      LEN: begin
        if (rx_valid) begin
          len_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          state_d = is_rd_q ? RREQ : WDATA;
        end
      end
      WDATA: if (rx_valid) begin start_wr = 1'b1; state_d = WRITE; end
      WRITE: begin
        if (bp_done) begin
          addr_d = addr_q + 16'd1;
          len_d  = len_q - 9'd1;
          if (len_q == 9'd1) begin
            ack_d   = BYTE_ACK;
            state_d = ACK;
          end else begin
            state_d = WDATA;
          end
        end
      end
      RREQ: begin start_rd = 1'b1; state_d = RWAIT; end
      RWAIT: begin
        if (bp_done) begin
          rdata_d = bp_rdata;
          if (bp_timeout) err = 1'b1;
          addr_d  = addr_q + 16'd1;
          len_d   = len_q - 9'd1;
          state_d = RSEND;
        end
      end
      RSEND: begin
        if (tx_ok) begin
          tx_fire = 1'b1;
          tx_byte = rdata_q;
          state_d = (len_q == 9'd0) ? IDLE : RREQ;
        end
      end
      ACK: begin
        if (tx_ok) begin
          tx_fire = 1'b1;
          tx_byte = ack_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      is_rd_q     <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= '0;
      tx_data_q   <= '0;
      tx_wr_en_q  <= 1'b0;
      cmd_error_q <= 1'b0;
      cpu_halt_q  <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      is_rd_q     <= is_rd_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      tx_data_q   <= tx_byte;
      tx_wr_en_q  <= tx_fire;
      cmd_error_q <= err;
      cpu_halt_q  <= (state_d != IDLE);
      if (tx_fire)           gap_q <= 2'd2;
      else if (gap_q != '0)  gap_q <= gap_q - 2'd1;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_wr_en  = tx_wr_en_q;
  assign cmd_error = cmd_error_q;
  assign cpu_halt  = cpu_halt_q;

endmodule

// File: tb/tb_uart_bus_loader.sv
// Scoreboard bench: a command-level model queues expected tx bytes, bus
// writes, read addresses and error pulses; a monitor pops and compares.
module tb_uart_bus_loader;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  logic       tx_busy;
  logic       cpu_halt;
  logic       cmd_error;

  uart_bus_loader_if bus_if ();

  uart_bus_loader #(
    .BUS_WAIT_MAX(255),
    .READ_SETTLE (2)
  ) dut (
    .sys_clk  (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_wr_en (tx_wr_en),
    .tx_busy  (tx_busy),
    .cpu_halt (cpu_halt),
    .cmd_error(cmd_error),
    .bus      (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  rsp_mem [0:65535];
  logic [7:0]  exp_tx [$];
  logic [23:0] exp_wr [$];
  logic [15:0] exp_rd [$];
  logic [7:0]  no_data [$];
  int exp_err;
  int err_seen;
  int rsp_wait;
  bit rsp_stall;

  int mcyc;
  int last_tx;
  bit prev_wr;
  bit prev_rd;
  logic [15:0] rd_addr;
  int rcnt;
  int bcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // Monitor, UART busy model and memory responder share one process so their
  // per-cycle ordering is fixed: compare first, then drive the next inputs.
  initial begin
    tx_busy = 1'b0;
    bus_if.bus_ready   = 1'b0;
    bus_if.bus_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      mcyc++;
      if (!reset) begin
        if (tx_wr_en) begin
          check("tx_spacing_busy", {31'b0, ((mcyc - last_tx) >= 3) && !tx_busy}, 32'd1);
          last_tx = mcyc;
          if (exp_tx.size() == 0) unexpected("tx_byte");
          else check("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
        end
        if (cmd_error) err_seen++;
        if (bus_if.bus_wr_en) begin
          if (exp_wr.size() == 0) unexpected("bus_write");
          else check("bus_write",
                     {6'b0, prev_wr, bus_if.bus_rd_req, bus_if.bus_addr, bus_if.bus_wr_data},
                     {8'b0, exp_wr.pop_front()});
          rsp_mem[bus_if.bus_addr] = bus_if.bus_wr_data;
        end
        if (bus_if.bus_rd_req && !prev_rd) begin
          rd_addr = bus_if.bus_addr;
          if (exp_rd.size() == 0) unexpected("bus_read");
          else check("bus_read_addr", {16'b0, bus_if.bus_addr}, {16'b0, exp_rd.pop_front()});
        end else if (bus_if.bus_rd_req) begin
          check("rd_addr_hold", {16'b0, bus_if.bus_addr}, {16'b0, rd_addr});
        end
      end
      prev_wr = bus_if.bus_wr_en;
      prev_rd = bus_if.bus_rd_req;
      if (bcnt > 0) begin tx_busy = 1'b1; bcnt--; end
      else tx_busy = 1'b0;
      if (tx_wr_en && !reset) bcnt = $urandom_range(0, 5);
      if (bus_if.bus_rd_req) begin
        rcnt++;
        bus_if.bus_ready   = !rsp_stall && (rcnt > rsp_wait);
        bus_if.bus_rd_data = rsp_mem[bus_if.bus_addr];
      end else begin
        rcnt = 0;
        bus_if.bus_ready   = 1'b0;
        bus_if.bus_rd_data = 8'h00;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0 || exp_rd.size() != 0 || cpu_halt) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    check("pending_events", exp_tx.size() + exp_wr.size() + exp_rd.size(), 32'd0);
    check("halt_low", {31'b0, cpu_halt}, 32'd0);
    check("cmd_error_count", err_seen, exp_err);
    exp_tx.delete();
    exp_wr.delete();
    exp_rd.delete();
    err_seen = exp_err;
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [15:0] addr, input logic [7:0] len,
                         input logic [7:0] dq[$], input int wt, input bit stall, input bit spurious);
    int n;
    logic [15:0] a;
    n = (len == 8'd0) ? 256 : int'(len);
    rsp_wait  = wt;
    rsp_stall = stall;
    case (op)
      8'h57: begin
        for (int i = 0; i < n; i++) begin
          a = addr + 16'(i);
          exp_wr.push_back({a, dq[i]});
          ref_mem[a] = dq[i];
        end
        exp_tx.push_back(8'h2E);
      end
      8'h52: begin
        for (int i = 0; i < n; i++) begin
          a = addr + 16'(i);
          exp_rd.push_back(a);
          if (stall) begin exp_tx.push_back(8'hFF); exp_err++; end
          else exp_tx.push_back(ref_mem[a]);
        end
      end
      8'h50: exp_tx.push_back(8'h50);
      default: begin exp_tx.push_back(8'h3F); exp_err++; end
    endcase
    send_byte(op);
    check("halt_rise", {31'b0, cpu_halt}, 32'd1);
    if (op == 8'h57 || op == 8'h52) begin
      send_byte(addr[7:0]);
      send_byte(addr[15:8]);
      send_byte(len);
      if (op == 8'h57) begin
        for (int i = 0; i < n; i++) begin
          repeat ($urandom_range(1, 3)) @(negedge clk);
          send_byte(dq[i]);
        end
      end
    end
    if (spurious) begin
      for (int k = 0; k < 200 && !bus_if.bus_rd_req; k++) @(negedge clk);
      check("spurious_rd_req_seen", {31'b0, bus_if.bus_rd_req}, 32'd1);
      send_byte(8'h99);
      exp_err++;
    end
    wait_idle();
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] v;
    logic [7:0] op;
    int r;
    n_tests = 0; n_fail = 0; exp_err = 0; err_seen = 0;
    rsp_wait = 0; rsp_stall = 1'b0;
    mcyc = 0; last_tx = -10; prev_wr = 1'b0; prev_rd = 1'b0; rd_addr = '0; rcnt = 0; bcnt = 0;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      rsp_mem[i] = v;
    end
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {19'b0, tx_data, tx_wr_en, cmd_error, cpu_halt, bus_if.bus_wr_en, bus_if.bus_rd_req}, 32'd0);
    check("reset_bus", {8'b0, bus_if.bus_addr, bus_if.bus_wr_data}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(8'h50, 16'h0000, 8'h00, no_data, 0, 1'b0, 1'b0);
    q = '{8'hAA, 8'hBB, 8'hCC};
    run_cmd(8'h57, 16'h4000, 8'h03, q, 0, 1'b0, 1'b0);
    run_cmd(8'h52, 16'h4000, 8'h03, no_data, 5, 1'b0, 1'b0);
    run_cmd(8'h52, 16'hFFFF, 8'h02, no_data, 0, 1'b1, 1'b0);
    q.delete();
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
    run_cmd(8'h57, 16'hFFFF, 8'h00, q, 0, 1'b0, 1'b0);
    run_cmd(8'h52, 16'hFFFE, 8'h04, no_data, 1, 1'b0, 1'b0);
    run_cmd(8'h41, 16'h0000, 8'h00, no_data, 0, 1'b0, 1'b0);
    run_cmd(8'h52, 16'h4001, 8'h02, no_data, 6, 1'b0, 1'b1);

    // Reset during the second data byte of a 4-byte write.
    exp_wr.push_back({16'h5000, 8'h11});
    ref_mem[16'h5000] = 8'h11;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h50); send_byte(8'h04);
    repeat (2) @(negedge clk);
    send_byte(8'h11);
    repeat (2) @(negedge clk);
    rx_data = 8'h22; rx_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("midcmd_reset_ctrl", {19'b0, tx_data, tx_wr_en, cmd_error, cpu_halt, bus_if.bus_wr_en, bus_if.bus_rd_req}, 32'd0);
    check("midcmd_reset_bus", {8'b0, bus_if.bus_addr, bus_if.bus_wr_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_pending", exp_wr.size() + exp_tx.size(), 32'd0);
    check("post_reset_errors", err_seen, exp_err);
    run_cmd(8'h50, 16'h0000, 8'h00, no_data, 0, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      r = $urandom_range(0, 9);
      if (r < 4) op = 8'h57;
      else if (r < 8) op = 8'h52;
      else if (r == 8) op = 8'h50;
      else begin
        do op = 8'($urandom); while (op == 8'h57 || op == 8'h52 || op == 8'h50);
      end
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
      run_cmd(op, ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom),
              8'($urandom_range(1, 6)), q, $urandom_range(0, 6), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_bus_loader.md
UART_BUS_LOADER -- requirements
Module: uart_bus_loader

Interface
REQ-001 SHALL have parameter BUS_WAIT_MAX, default 255, the maximum cycles to wait for bus_ready on a read before the read times out.
REQ-002 SHALL have parameter READ_SETTLE, default 2, the number of cycles after bus_rd_req rises during which bus_ready is ignored.
REQ-003 sys_clk  in  1  sole clock; all logic on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  received UART byte.
REQ-006 rx_valid  in  1  one-cycle strobe: rx_data is valid.
REQ-007 tx_data  out  8  byte to transmit.
REQ-008 tx_wr_en  out  1  one-cycle strobe: load tx_data into the UART.
REQ-009 tx_busy  in  1  UART transmitter busy.
REQ-010 bus_addr  out  16  bus address.
REQ-011 bus_wr_data  out  8  write data.
REQ-012 bus_wr_en  out  1  one-cycle write strobe.
REQ-013 bus_rd_req  out  1  read request, held high until the read completes.
REQ-014 bus_rd_data  in  8  read data.
REQ-015 bus_ready  in  1  responder ready; low means wait-state.
REQ-016 cpu_halt  out  1  high from the first byte of a command until it completes; holds the CPU off the bus.
REQ-017 cmd_error  out  1  one-cycle pulse on a protocol error or bus timeout.

Function
REQ-018 Command format SHALL be: opcode, addr_lo, addr_hi, len. len=0 means 256 bytes.
REQ-019 Opcode 0x57 'W' SHALL be followed by len data bytes. Data byte i SHALL be written to addr+i, where the address is 16 bits and wraps modulo 65536. When all bytes are written, the block SHALL transmit ack byte 0x2E.
REQ-020 Opcode 0x52 'R' SHALL read addr+i for i=0..len-1 and transmit each byte as it is read, with the same 16-bit wrap. No ack byte SHALL be sent.
REQ-021 Opcode 0x50 'P' SHALL take no operands and transmit 0x50.
REQ-022 Any other opcode SHALL cause transmission of 0x3F, pulse cmd_error, and return to IDLE.
REQ-023 FSM states SHALL be: IDLE, ADDR_LO, ADDR_HI, LEN, WDATA, WRITE, RREQ, RWAIT, RSEND, ACK.
- Each receive state advances on rx_valid.
- The WDATA, WRITE sequence repeats len times.
- The RREQ, RWAIT, RSEND sequence repeats len times.
- ACK and the last RSEND return to IDLE.
REQ-024 A write SHALL be a single cycle with bus_wr_en=1 and bus_addr/bus_wr_data stable in that cycle. At least one idle cycle SHALL follow each write.
REQ-025 A read SHALL raise bus_rd_req with bus_addr stable, ignore bus_ready for READ_SETTLE cycles, then latch bus_rd_data in the first cycle bus_ready=1.
REQ-026 After each read, bus_rd_req SHALL be low for at least one cycle before the next read, so every read presents a fresh rising edge.
REQ-027 If bus_ready stays low for BUS_WAIT_MAX cycles after the settle period, the block SHALL:
- use 0xFF as the read data;
- pulse cmd_error;
- continue with the next byte.
REQ-028 tx_wr_en SHALL pulse only when tx_busy=0. It SHALL NOT pulse again within 2 cycles of the previous pulse, to cover UART busy latency.
REQ-029 rx_valid arriving in RREQ, RWAIT, RSEND, WRITE or ACK SHALL drop the byte and pulse cmd_error; the current command continues.
REQ-030 If rx_valid and a bus completion occur in the same cycle, the bus completion SHALL be processed and the rx byte handled per REQ-029.
REQ-031 cpu_halt SHALL rise in the cycle after the opcode is accepted and fall in the cycle after return to IDLE.
REQ-032 bus_wr_en and bus_rd_req SHALL never be high in the same cycle.

Reset
REQ-033 While reset=1, all of the following SHALL be 0 at the next edge: bus_wr_en, bus_rd_req, tx_wr_en, cmd_error, cpu_halt, bus_addr, bus_wr_data, tx_data.
REQ-034 On reset the FSM SHALL enter IDLE, clearing the address and length counters.
REQ-035 Reset mid-command SHALL abort the command with no further bus or tx activity.

Structure
REQ-036 Opcode constants, ack/error byte constants and the state encoding SHALL live in shared package loader_pkg.
REQ-037 The read/write handshake and timeout counter SHALL be one sub-module, bus_port, with a start/done interface to the command FSM.

Verification
REQ-038 Ping: rx 0x50 -> one tx 0x50; no bus activity; cpu_halt high then low.
REQ-039 Write: rx 57 00 40 03 AA BB CC -> bus writes 0x4000=AA, 0x4001=BB, 0x4002=CC, each a single-cycle strobe; then tx 0x2E.
REQ-040 Read with wait-states: memory 0x4000..2 = AA BB CC, responder ready low for 5 cycles per read; rx 52 00 40 03 -> tx AA BB CC; bus_rd_req low for at least 1 cycle between reads.
REQ-041 Wrap and timeout:
- rx 52 FF FF 02 with bus_ready held low -> reads 0xFFFF then 0x0000; tx FF FF; two cmd_error pulses.
- rx 57 FF FF 00 followed by 256 bytes -> 256 writes wrapping to 0x00FE; tx 0x2E.
REQ-042 Error and reset: rx 0x41 -> tx 0x3F and one cmd_error pulse. Separately, assert reset during the 2nd data byte of a 4-byte write -> no further writes, all outputs 0, and a following ping succeeds.
